// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared state encoding and address defaults for the SRAM memory controller
`timescale 1ns/1ps
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int unsigned DEFAULT_BASE_ADDR = 1024;

endpackage

// File: rtl/sram_wait_counter.sv
// rtl/sram_wait_counter.sv - 4-bit loadable down-counter timing one SRAM half-word access
`timescale 1ns/1ps
module sram_wait_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_en,
  output logic       o_zero
);

  logic [3:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= 4'd0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      r_count <= r_count - 4'd1;
    end
  end

  assign o_zero = (r_count == 4'd0);

endmodule

// File: rtl/sram_mem_controller.sv
// rtl/sram_mem_controller.sv - MEM-stage controller serving 32-bit word accesses as two 16-bit SRAM half-word accesses
`timescale 1ns/1ps
module sram_mem_controller
  import mem_ctrl_pkg::*;
#(
  parameter int          ACCESS_CYCLES = 2,
  parameter int unsigned BASE_ADDR     = DEFAULT_BASE_ADDR,
  parameter int          SRAM_AW       = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  inout  wire  [15:0]        SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_is_wr;
  logic [SRAM_AW-2:0] r_word;
  logic [31:0]        r_wdata;

  logic               w_req;
  logic [SRAM_AW-2:0] w_word;
  logic               w_zero;
  logic               w_load;
  logic               w_en;
  logic               w_ready;
  logic               w_we_n;
  logic               w_oe_n;
  logic               w_drive;
  logic [SRAM_AW-1:0] w_addr;
  logic [15:0]        w_dq_out;

  assign w_req  = rd_en | wr_en;
  // Word index wraps modulo the SRAM size; out-of-range addresses are not flagged.
  assign w_word = (SRAM_AW-1)'((address - 32'(BASE_ADDR)) >> 2);

  sram_wait_counter u_wait_counter (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (4'(ACCESS_CYCLES - 1)),
    .i_en       (w_en),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b1;
    w_load      = 1'b0;
    w_en        = 1'b0;
    w_we_n      = 1'b1;
    w_oe_n      = 1'b1;
    w_drive     = 1'b0;
    w_addr      = '0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_ready     = 1'b0;
          w_load      = 1'b1;
          w_state_nxt = S_LO;
        end
      end
      S_LO, S_HI: begin
        w_ready = 1'b0;
        w_addr  = {r_word, (r_state == S_HI)};
        w_drive = r_is_wr;
        w_oe_n  = r_is_wr;
        // Strobe released on the final cycle of each half so data is held past WE_N rising.
        w_we_n  = !(r_is_wr && !w_zero);
        if (w_zero) begin
          w_load      = (r_state == S_LO);
          w_state_nxt = (r_state == S_LO) ? S_HI : S_DONE;
        end else begin
          w_en = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_is_wr   <= 1'b0;
      r_word    <= '0;
      r_wdata   <= '0;
      read_data <= '0;
    end else begin
      if (r_state == S_IDLE && w_req) begin
        r_is_wr <= wr_en;
        r_word  <= w_word;
        r_wdata <= write_data;
      end
      if (!r_is_wr && w_zero && r_state == S_LO) begin
        read_data[15:0] <= SRAM_DQ;
      end
      if (!r_is_wr && w_zero && r_state == S_HI) begin
        read_data[31:16] <= SRAM_DQ;
      end
    end
  end

  assign w_dq_out  = (r_state == S_HI) ? r_wdata[31:16] : r_wdata[15:0];
  assign SRAM_DQ   = w_drive ? w_dq_out : 16'hzzzz;
  assign SRAM_ADDR = w_addr;
  assign SRAM_WE_N = w_we_n;
  assign SRAM_OE_N = w_oe_n;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign ready     = rst ? w_ready : 1'b1;

endmodule
